joy_conditioner: RTL and testbench

//  Consumer of the two 12-bit active-low Mega Drive/passive joystick words (MXYZ SACB RLDU).

---
 rtl/joy_pkg.sv | 29 ++
 rtl/joy_channel_cond.sv | 66 ++++++
 rtl/joy_conditioner.sv | 116 +++++++++++
 tb/tb_joy_conditioner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared joystick definitions: bit positions of the MXYZ SACB RLDU word,
// the set of bits that may autofire, and the Kempston byte mapping.
package joy_pkg;

    typedef logic [11:0] joy_word_t;
    typedef logic [7:0]  kemp_byte_t;

    localparam int JOY_U = 0;
    localparam int JOY_D = 1;
    localparam int JOY_L = 2;
    localparam int JOY_R = 3;
    localparam int JOY_B = 4;
    localparam int JOY_C = 5;
    localparam int JOY_A = 6;
    localparam int JOY_S = 7;
    localparam int JOY_Z = 8;
    localparam int JOY_Y = 9;
    localparam int JOY_X = 10;
    localparam int JOY_M = 11;

    // Fire buttons only (B, C, A, Z, Y, X); directions, Start and Mode never autofire.
    localparam joy_word_t JOY_AF_ALLOWED = 12'b0111_0111_0000;

    function automatic kemp_byte_t joyKempston(input joy_word_t w);
        return {w[JOY_S], w[JOY_A], w[JOY_C], w[JOY_B],
                w[JOY_U], w[JOY_D], w[JOY_L], w[JOY_R]};
    endfunction

endpackage

// File: rtl/joy_channel_cond.sv
// One joystick channel: invert, 2-FF synchronise, per-bit debounce on
// sample_tick, then cancel opposing directions (SOCD) on the stable word.
module joy_channel_cond
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      sample_tick_i,
    input  joy_word_t joy_n_i,
    output joy_word_t cond_o
);

    joy_word_t        syncMeta_q;
    joy_word_t        sync_q;
    joy_word_t        stable_q;
    joy_word_t        stable_d;
    logic [11:0][3:0] cnt_q;
    logic [11:0][3:0] cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncMeta_q <= '0;
            sync_q     <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
        end else begin
            syncMeta_q <= ~joy_n_i;
            sync_q     <= syncMeta_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
        end
    end

    // A bit must disagree with its stable value on DEBOUNCE_SAMPLES consecutive ticks.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sample_tick_i) begin
            for (int b = 0; b < 12; b++) begin
                if (sync_q[b] == stable_q[b]) begin
                    cnt_d[b] = 4'd0;
                end else if (cnt_q[b] + 4'd1 == 4'(DEBOUNCE_SAMPLES)) begin
                    stable_d[b] = sync_q[b];
                    cnt_d[b]    = 4'd0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        cond_o = stable_q;
        if (stable_q[JOY_L] && stable_q[JOY_R]) begin
            cond_o[JOY_L] = 1'b0;
            cond_o[JOY_R] = 1'b0;
        end
        if (stable_q[JOY_U] && stable_q[JOY_D]) begin
            cond_o[JOY_U] = 1'b0;
            cond_o[JOY_D] = 1'b0;
        end
    end

endmodule

// File: rtl/joy_conditioner.sv
// Conditions both joysticks into active-high words and Kempston bytes.
// Define JOY_AUTOFIRE_EN to build the shared autofire divider and per-bit masks.
module joy_conditioner
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int AUTOFIRE_DIV     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic [11:0] joy1_n,
    input  logic [11:0] joy2_n,
    input  logic [11:0] af_mask1,
    input  logic [11:0] af_mask2,
    output logic [11:0] joy1_q,
    output logic [11:0] joy2_q,
    output logic [7:0]  kemp1,
    output logic [7:0]  kemp2,
    output logic        changed
);

    joy_word_t cond1;
    joy_word_t cond2;
    joy_word_t joy1_d;
    joy_word_t joy2_d;
    joy_word_t prev1_q;
    joy_word_t prev2_q;

    joy_channel_cond #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_chan1 (
        .clk           (clk),
        .reset         (reset),
        .sample_tick_i (sample_tick),
        .joy_n_i       (joy1_n),
        .cond_o        (cond1)
    );

    joy_channel_cond #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_chan2 (
        .clk           (clk),
        .reset         (reset),
        .sample_tick_i (sample_tick),
        .joy_n_i       (joy2_n),
        .cond_o        (cond2)
    );

`ifdef JOY_AUTOFIRE_EN
    logic [7:0] afDiv_q;
    logic [7:0] afDiv_d;
    logic       afPhase_q;
    logic       afPhase_d;
    joy_word_t  afEn1;
    joy_word_t  afEn2;

    always_ff @(posedge clk) begin
        if (reset) begin
            afDiv_q   <= 8'd0;
            afPhase_q <= 1'b0;
        end else begin
            afDiv_q   <= afDiv_d;
            afPhase_q <= afPhase_d;
        end
    end

    // One divider shared by both joysticks so all autofire bits pulse in step.
    always_comb begin
        afDiv_d   = afDiv_q;
        afPhase_d = afPhase_q;
        if (sample_tick) begin
            if (afDiv_q == 8'(AUTOFIRE_DIV - 1)) begin
                afDiv_d   = 8'd0;
                afPhase_d = ~afPhase_q;
            end else begin
                afDiv_d = afDiv_q + 8'd1;
            end
        end
    end

    always_comb begin
        afEn1  = af_mask1 & JOY_AF_ALLOWED;
        afEn2  = af_mask2 & JOY_AF_ALLOWED;
        joy1_d = (cond1 & ~afEn1) | (cond1 & afEn1 & {12{afPhase_q}});
        joy2_d = (cond2 & ~afEn2) | (cond2 & afEn2 & {12{afPhase_q}});
    end
`else
    logic afMaskUnused;

    assign afMaskUnused = ^{af_mask1, af_mask2};

    always_comb begin
        joy1_d = cond1;
        joy2_d = cond2;
    end
`endif

    // changed compares the registered outputs with their previous values, so it trails them by one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            joy1_q  <= '0;
            joy2_q  <= '0;
            kemp1   <= '0;
            kemp2   <= '0;
            prev1_q <= '0;
            prev2_q <= '0;
            changed <= 1'b0;
        end else begin
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            kemp1   <= joyKempston(joy1_d);
            kemp2   <= joyKempston(joy2_d);
            prev1_q <= joy1_q;
            prev2_q <= joy2_q;
            changed <= (joy1_q != prev1_q) || (joy2_q != prev2_q);
        end
    end

endmodule

// File: tb/tb_joy_conditioner.sv
// Self-checking bench for joy_conditioner: directed scenarios plus random
// stimulus against a tick-counting reference model (honours JOY_AUTOFIRE_EN).
module tb_joy_conditioner;

    localparam int DS  = 3;
    localparam int AFD = 4;

    logic        clk;
    logic        reset;
    logic        sample_tick;
    logic [11:0] joy1_n, joy2_n, af_mask1, af_mask2;
    logic [11:0] joy1_q, joy2_q;
    logic [7:0]  kemp1, kemp2;
    logic        changed;

    int vectors    = 0;
    int miscompares = 0;
    int pulses     = 0;

    logic [11:0] curJ1, curJ2, curM1, curM2;

    joy_conditioner #(.DEBOUNCE_SAMPLES(DS), .AUTOFIRE_DIV(AFD)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .joy1_n      (joy1_n),
        .joy2_n      (joy2_n),
        .af_mask1    (af_mask1),
        .af_mask2    (af_mask2),
        .joy1_q      (joy1_q),
        .joy2_q      (joy2_q),
        .kemp1       (kemp1),
        .kemp2       (kemp2),
        .changed     (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [11:0] in1Last, in1Prev, in2Last, in2Prev;
    logic [11:0] mStable1, mStable2;
    int          run1 [12];
    int          run2 [12];
    int          mTicks;
    logic [11:0] eJoy1, eJoy2, pJoy1, pJoy2;
    logic        eChg;
    logic        checkEn = 1'b0;
    logic [11:0] newJ1, newJ2;
    logic        phase;

    function automatic logic [11:0] socdRef(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        if (s[2] && s[3]) begin r[2] = 1'b0; r[3] = 1'b0; end
        if (s[0] && s[1]) begin r[0] = 1'b0; r[1] = 1'b0; end
        return r;
    endfunction

    function automatic logic [11:0] afRef(input logic [11:0] s, input logic [11:0] m, input logic ph);
        logic [11:0] r;
        r = s;
`ifdef JOY_AUTOFIRE_EN
        for (int b = 0; b < 12; b++)
            if ((b == 4 || b == 5 || b == 6 || b == 8 || b == 9 || b == 10) && m[b])
                r[b] = s[b] & ph;
`endif
        return r;
    endfunction

    function automatic logic [7:0] kempRef(input logic [11:0] j);
        return {j[7], j[6], j[5], j[4], j[0], j[1], j[2], j[3]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            in1Last = '0; in1Prev = '0; in2Last = '0; in2Prev = '0;
            mStable1 = '0; mStable2 = '0;
            for (int b = 0; b < 12; b++) begin run1[b] = 0; run2[b] = 0; end
            mTicks = 0;
            eJoy1 = '0; eJoy2 = '0; pJoy1 = '0; pJoy2 = '0; eChg = 1'b0;
            checkEn = 1'b1;
        end else begin
            phase = ((mTicks / AFD) % 2) == 1;
            newJ1 = afRef(socdRef(mStable1), af_mask1, phase);
            newJ2 = afRef(socdRef(mStable2), af_mask2, phase);
            eChg  = (eJoy1 != pJoy1) || (eJoy2 != pJoy2);
            pJoy1 = eJoy1; pJoy2 = eJoy2;
            eJoy1 = newJ1; eJoy2 = newJ2;
            if (sample_tick) begin
                for (int b = 0; b < 12; b++) begin
                    if (in1Prev[b] != mStable1[b]) begin
                        run1[b]++;
                        if (run1[b] >= DS) begin mStable1[b] = in1Prev[b]; run1[b] = 0; end
                    end else run1[b] = 0;
                    if (in2Prev[b] != mStable2[b]) begin
                        run2[b]++;
                        if (run2[b] >= DS) begin mStable2[b] = in2Prev[b]; run2[b] = 0; end
                    end else run2[b] = 0;
                end
                mTicks++;
            end
            in1Prev = in1Last; in1Last = ~joy1_n;
            in2Prev = in2Last; in2Last = ~joy2_n;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("joy1_q", 32'(joy1_q), 32'(eJoy1));
            checkOutput("joy2_q", 32'(joy2_q), 32'(eJoy2));
            checkOutput("kemp1",  32'(kemp1),  32'(kempRef(eJoy1)));
            checkOutput("kemp2",  32'(kemp2),  32'(kempRef(eJoy2)));
            checkOutput("changed", 32'(changed), 32'(eChg));
            if (changed) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic rst, input logic tick);
        reset       = rst;
        sample_tick = tick;
        joy1_n      = curJ1;
        joy2_n      = curJ2;
        af_mask1    = curM1;
        af_mask2    = curM2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            applyStimulus(1'b0, 1'b1);
            idle(3);
        end
    endtask

    initial begin
        curJ1 = 12'h000; curJ2 = 12'hFFF; curM1 = '0; curM2 = '0;
        // Test 1: reset, then all-pressed joystick 1
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_joy1", 32'(joy1_q), 32'h0);
        checkOutput("rst_kemp1", 32'(kemp1), 32'h0);
        checkOutput("rst_changed", 32'(changed), 32'h0);
        idle(3); ticks(3);
        checkOutput("t1_joy1", 32'(joy1_q), 32'hFF0);
        checkOutput("t1_kemp1", 32'(kemp1), 32'hF0);

        // Test 2: short B press rejected, full press accepted
        curJ1 = 12'hFFF; idle(3); ticks(3); idle(2);
        pulses = 0;
        curJ1 = 12'hFEF; idle(3); ticks(2);
        curJ1 = 12'hFFF; idle(3); ticks(3); idle(2);
        checkOutput("t2_short_joy1", 32'(joy1_q), 32'h0);
        checkOutput("t2_short_pulses", 32'(pulses), 32'd0);
        curJ1 = 12'hFEF; idle(3); ticks(3); idle(2);
        checkOutput("t2_joy1", 32'(joy1_q), 32'h010);
        checkOutput("t2_kemp1", 32'(kemp1), 32'h10);
        checkOutput("t2_pulses", 32'(pulses), 32'd1);

        // Test 3: L+R cancel on joystick 2
        curJ2 = 12'hFF3; idle(3); ticks(3);
        checkOutput("t3_socd", 32'(joy2_q), 32'h000);
        curJ2 = 12'hFF7; idle(3); ticks(3);
        checkOutput("t3_joy2", 32'(joy2_q), 32'h008);
        checkOutput("t3_kemp2", 32'(kemp2), 32'h01);

        // Test 5: reset mid-debounce discards partial count
        curJ1 = 12'hFFE; idle(3); ticks(2);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t5_rst_joy1", 32'(joy1_q), 32'h0);
        checkOutput("t5_rst_joy2", 32'(joy2_q), 32'h0);
        checkOutput("t5_rst_changed", 32'(changed), 32'h0);
        idle(3); ticks(2);
        checkOutput("t5_partial", 32'(joy1_q), 32'h0);
        ticks(1);
        checkOutput("t5_joy1", 32'(joy1_q), 32'h001);

`ifdef JOY_AUTOFIRE_EN
        // Test 4: autofire on B toggles, on U ignored
        curM1 = 12'h010; curJ1 = 12'hFEF; idle(3); ticks(3);
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            checkOutput("t4_af_b", 32'(joy1_q[4]), 32'(((mTicks / AFD) % 2) == 1));
        end
        curM1 = 12'h001; curJ1 = 12'hFFE; idle(3); ticks(3);
        for (int i = 0; i < 8; i++) begin
            ticks(1);
            checkOutput("t4_af_u", 32'(joy1_q[0]), 32'h1);
        end
`else
        // Test 6: masks ignored without autofire
        curM1 = 12'hFFF; curJ1 = 12'hFEF; idle(3); ticks(3);
        for (int i = 0; i < 8; i++) begin
            ticks(1);
            checkOutput("t6_no_af_b", 32'(joy1_q[4]), 32'h1);
        end
`endif

        // Random phase: bouncing bits, random ticks, masks and resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7, 0) == 0) curJ1 ^= 12'(1) << $urandom_range(11, 0);
            if ($urandom_range(7, 0) == 0) curJ2 ^= 12'(1) << $urandom_range(11, 0);
            if ($urandom_range(199, 0) == 0) curM1 = 12'($urandom);
            if ($urandom_range(199, 0) == 0) curM2 = 12'($urandom);
            applyStimulus($urandom_range(599, 0) == 0, $urandom_range(2, 0) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
